bcd_serial_subtractor: RTL and testbench

//  Multi-digit BCD subtractor: diff = a - b - bin, one decimal digit per clock, LSD first.

---
 rtl/bcd_pkg.sv | 11 +
 rtl/bcd_digit_sub.sv | 19 +
 rtl/bcd_serial_subtractor.sv | 131 +++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, serial-subtractor state encoding and digit validity helper.
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_RADIX   = 10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic logic is_bcd(input logic [BCD_DIGIT_W-1:0] digit);
        return digit < BCD_DIGIT_W'(BCD_RADIX);
    endfunction
endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: combinational single BCD digit subtract with borrow (d = a - b - bin, mod 10).
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   bin,
    output logic [BCD_DIGIT_W-1:0] d,
    output logic                   bout
);
    logic [BCD_DIGIT_W:0] t;

    // t spans -16..15, so bit 4 is the sign and doubles as the borrow.
    always_comb begin
        t    = {1'b0, a} - {1'b0, b} - {{BCD_DIGIT_W{1'b0}}, bin};
        bout = t[BCD_DIGIT_W];
        d    = bout ? t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(BCD_RADIX) : t[BCD_DIGIT_W-1:0];
    end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: multi-digit BCD diff = a - b - bin, one digit per clock, LSD first.
// Define BCD_CHECK_EN to flag operands containing non-BCD digits on err.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                bout,
    output logic                err
);
    localparam int W  = BCD_DIGIT_W * DIGITS;
    localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     a_sr_q, a_sr_d, b_sr_q, b_sr_d;
    logic [W-1:0]     res_q, res_d, diff_q, diff_d;
    logic             brw_q, brw_d, bout_q, bout_d;
    logic [BCD_DIGIT_W-1:0] dig;
    logic             dig_bout;
    logic             last;

    bcd_digit_sub u_digit (
        .a    (a_sr_q[BCD_DIGIT_W-1:0]),
        .b    (b_sr_q[BCD_DIGIT_W-1:0]),
        .bin  (brw_q),
        .d    (dig),
        .bout (dig_bout)
    );

    assign last = state_q == RUN && cnt_q == CW'(DIGITS - 1);

    // res_q collects digits MSD-in so digit 0 lands at the bottom after the last shift;
    // diff_q is only loaded on the way into DONE so the visible result never shows partials.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        brw_d   = brw_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                cnt_d   = '0;
                a_sr_d  = a;
                b_sr_d  = b;
                brw_d   = bin;
                res_d   = '0;
            end
            RUN: begin
                cnt_d  = cnt_q + CW'(1);
                a_sr_d = a_sr_q >> BCD_DIGIT_W;
                b_sr_d = b_sr_q >> BCD_DIGIT_W;
                brw_d  = dig_bout;
                res_d  = (res_q >> BCD_DIGIT_W) | (W'(dig) << (W - BCD_DIGIT_W));
                if (last) begin
                    state_d = DONE;
                    diff_d  = res_d;
                    bout_d  = dig_bout;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            brw_q   <= brw_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign diff = diff_q;
    assign bout = bout_q;

`ifdef BCD_CHECK_EN
    logic bad, chk_q, chk_d, err_q, err_d;

    // Operands are judged once at latch time; the verdict is published alongside diff.
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | !is_bcd(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) | !is_bcd(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        chk_d = (state_q == IDLE && start) ? bad : chk_q;
        err_d = last ? chk_q : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: directed and random operands against a decimal-integer reference model.
module tb_bcd_serial_subtractor;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst, start, bin;
    logic [W-1:0] a, b, diff;
    logic         busy, done, bout, err;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .err   (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bcd_val(input logic [W-1:0] x);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(x[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] x);
        logic r = 1'b0;
        for (int i = 0; i < DIGITS; i++) r = r | (x[i*4 +: 4] > 4'd9);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(9));
        return r;
    endfunction

    // Drives one operation; with poke set, new operands and start are pushed mid-RUN and must be ignored.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin, input bit poke);
        int           lat;
        int           r;
        logic [W-1:0] exp_diff;
        logic         exp_bout, exp_err, valid;
        r        = bcd_val(xa) - bcd_val(xb) - int'(xbin);
        exp_bout = r < 0;
        if (r < 0) r = r + 10 ** DIGITS;
        exp_diff = to_bcd(r);
        valid    = !has_bad(xa) && !has_bad(xb);
`ifdef BCD_CHECK_EN
        exp_err  = !valid;
`else
        exp_err  = 1'b0;
`endif
        @(negedge clk);
        a = xa; b = xb; bin = xbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            check("busy_run", busy, 1);
            if (poke && lat == 1) begin
                a = rand_bcd(); b = rand_bcd(); bin = ~xbin; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, DIGITS);
        check("busy_at_done", busy, 0);
        if (valid) begin
            check("diff", diff, exp_diff);
            check("bout", bout, exp_bout);
        end
        check("err", err, exp_err);
        @(negedge clk);
        check("done_pulse", done, 0);
        if (valid) check("diff_hold", diff, exp_diff);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("wait_done", done, 1);
    endtask

    initial begin
        int  lat;
        bit  saw_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        run_op(16'h0042, 16'h0017, 1'b0, 1'b0);
        check("dir_0042_0017", diff, 16'h0025);
        run_op(16'h0017, 16'h0042, 1'b0, 1'b0);
        check("dir_0017_0042", diff, 16'h9975);
        run_op(16'h1000, 16'h0001, 1'b0, 1'b0);
        check("dir_ripple", diff, 16'h0999);
        run_op(16'h9999, 16'h9999, 1'b1, 1'b0);
        check("dir_all9_bin", {15'd0, bout, diff}, {15'd0, 1'b1, 16'h9999});
        run_op(16'h0042, 16'h0017, 1'b0, 1'b1);

        // start held through the done cycle is ignored there and taken in the following IDLE cycle
        @(negedge clk);
        a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        a = 16'h0017; b = 16'h0042; start = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", busy, 0);
        check("done_result", diff, 16'h0025);
        @(negedge clk);
        start = 1'b0;
        check("start_after_done_taken", busy, 1);
        wait_done(lat);
        check("second_diff", diff, 16'h9975);
        check("second_bout", bout, 1);

        // reset in the second RUN cycle discards the operation
        @(negedge clk);
        a = 16'h0042; b = 16'h0017; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_diff", diff, 0);
        check("midrst_bout", bout, 0);
        check("midrst_err", err, 0);
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            saw_done = saw_done | done | busy;
        end
        check("midrst_no_done", saw_done, 0);

        run_op(16'h00A3, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0001, 16'hF000, 1'b1, 1'b0);

        repeat (40) run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(1)), 1'b0);
        repeat (5) run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(1)), 1'b1);
        repeat (5) run_op(W'($urandom), W'($urandom), 1'($urandom_range(1)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
